// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: result-source select, load funct3,
// the stage state enum and the control-FSM state codes it hands back.
package writeback_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_NONE = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Codes from the core's control FSM (ctrl_states); wb_next is 3 bits wide.
  localparam logic [2:0] CTRL_STATE_FETCH = 3'd0;
  localparam logic [2:0] CTRL_STATE_WB    = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } wb_state_t;

endpackage

// File: rtl/writeback_load_align.sv
// Load aligner: picks the byte/halfword lane from a word-aligned read,
// sign/zero-extends it and flags misaligned or illegal load encodings.
module load_align
  import writeback_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (addr)
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      2'd3:    byte_lane = mem_rdata[31:24];
      default: byte_lane = mem_rdata[7:0];
    endcase
    half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU: data = {24'h0, byte_lane};
      F3_LH: begin
        data  = {{16{half_lane[15]}}, half_lane};
        fault = addr[0];
      end
      F3_LHU: begin
        data  = {16'h0, half_lane};
        fault = addr[0];
      end
      F3_LW: begin
        data  = mem_rdata;
        fault = |addr;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage of the multi-cycle RV32I core: selects ALU/PC+4/load result
// and issues a one-cycle register-file write. Optional WB_LOAD_TIMEOUT_EN adds a
// WAIT_MEM watchdog (TIMEOUT_CYCLES) and the bus_timeout pulse.
module writeback
  import writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  wb_sel,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus4,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        done,
  output logic        busy,
  output logic        load_fault,
`ifdef WB_LOAD_TIMEOUT_EN
  output logic        bus_timeout,
`endif
  output logic [2:0]  wb_next
);

  wb_state_t   state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;

  logic [1:0]  al_addr;
  logic [2:0]  al_funct3;
  logic [31:0] al_data;
  logic        al_fault;

  // One aligner serves both the IDLE-time fault check (live inputs) and the
  // WAIT_MEM data path (captured address and funct3).
  assign al_addr   = (state == IDLE) ? alu_result[1:0] : addr_q;
  assign al_funct3 = (state == IDLE) ? funct3 : funct3_q;

  load_align u_load_align (
    .addr      (al_addr),
    .funct3    (al_funct3),
    .mem_rdata (mem_rdata),
    .data      (al_data),
    .fault     (al_fault)
  );

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // NOTE: capture registers (funct3_q, addr_q, wait_cnt) are not reset; they are
  // always written before being read, so only control state and outputs need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      load_fault <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      bus_timeout <= 1'b0;
`endif
      wb_next    <= CTRL_STATE_WB;
    end else begin
      wr_en      <= 1'b0;
      done       <= 1'b0;
      load_fault <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      bus_timeout <= 1'b0;
`endif
      wb_next    <= CTRL_STATE_WB;

      case (state)
        IDLE: begin
          if (start) begin
            funct3_q <= funct3;
            addr_q   <= alu_result[1:0];
            w_addr   <= rd;
            busy     <= 1'b1;
            if (wb_sel == WB_SEL_MEM) begin
              if (al_fault) begin
                load_fault <= 1'b1;
                done       <= 1'b1;
                wb_next    <= CTRL_STATE_FETCH;
                state      <= WRITE;
              end else begin
`ifdef WB_LOAD_TIMEOUT_EN
                wait_cnt <= '0;
`endif
                state    <= WAIT_MEM;
              end
            end else begin
              wr_en   <= (rd != 5'd0) && (wb_sel != WB_SEL_NONE);
              w_data  <= (wb_sel == WB_SEL_PC4)  ? pc_plus4 :
                         (wb_sel == WB_SEL_NONE) ? 32'h0 : alu_result;
              done    <= 1'b1;
              wb_next <= CTRL_STATE_FETCH;
              state   <= WRITE;
            end
          end
        end

        WAIT_MEM: begin
          if (mem_rvalid) begin
            wr_en   <= (w_addr != 5'd0);
            w_data  <= al_data;
            done    <= 1'b1;
            wb_next <= CTRL_STATE_FETCH;
            state   <= WRITE;
          end
`ifdef WB_LOAD_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            bus_timeout <= 1'b1;
            done        <= 1'b1;
            wb_next     <= CTRL_STATE_FETCH;
            state       <= WRITE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        // Completion cycle: the registered pulses are visible now; go back to IDLE.
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: expected completions are queued when stimulus
// is driven and compared when done pulses; every cycle is also checked for stray pulses.
module tb_writeback;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        done;
  logic        busy;
  logic        load_fault;
  logic [2:0]  wb_next;
`ifdef WB_LOAD_TIMEOUT_EN
  logic        bus_timeout;
`endif

  writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wb_sel     (wb_sel),
    .rd         (rd),
    .funct3     (funct3),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wr_en      (wr_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .done       (done),
    .busy       (busy),
    .load_fault (load_fault),
`ifdef WB_LOAD_TIMEOUT_EN
    .bus_timeout(bus_timeout),
`endif
    .wb_next    (wb_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_data;
    logic        fault;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference load model: shift the word down to the addressed byte, then extend.
  function automatic void model_load(input logic [1:0] a, input logic [2:0] f3,
                                     input logic [31:0] w, output logic flt,
                                     output logic [31:0] d);
    logic [31:0] s;
    s   = w >> (8 * a);
    flt = 1'b0;
    d   = 32'h0;
    case (f3)
      3'b000: d = {{24{s[7]}}, s[7:0]};
      3'b001: begin flt = a[0]; d = {{16{s[15]}}, s[15:0]}; end
      3'b010: begin flt = (a != 2'b00); d = w; end
      3'b100: d = {24'h0, s[7:0]};
      3'b101: begin flt = a[0]; d = {16'h0, s[15:0]}; end
      default: flt = 1'b1;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("done_cycle", cyc, mon_e.due);
        check("wr_en", {31'h0, wr_en}, {31'h0, mon_e.wr});
        if (mon_e.wr) check("w_addr", {27'h0, w_addr}, {27'h0, mon_e.addr});
        if (mon_e.wr || mon_e.chk_data) check("w_data", w_data, mon_e.data);
        check("load_fault", {31'h0, load_fault}, {31'h0, mon_e.fault});
        check("wb_next_done", {29'h0, wb_next}, {29'h0, CTRL_STATE_FETCH});
`ifdef WB_LOAD_TIMEOUT_EN
        check("bus_timeout", {31'h0, bus_timeout}, {31'h0, mon_e.tmo});
`endif
      end
    end else begin
      check("wb_next_idle", {29'h0, wb_next}, {29'h0, CTRL_STATE_WB});
      check("stray_wr_en", {31'h0, wr_en}, 32'h0);
      check("stray_fault", {31'h0, load_fault}, 32'h0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_done", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic push(input int due, input logic wr, input logic [4:0] a,
                      input logic [31:0] d, input logic cd, input logic flt, input logic tmo);
    exp_t e;
    e.due = due; e.wr = wr; e.addr = a; e.data = d; e.chk_data = cd;
    e.fault = flt; e.tmo = tmo;
    q.push_back(e);
  endtask

  // Non-memory writeback: completes on the edge that samples start.
  task automatic do_reg(input logic [1:0] sel, input logic [4:0] r,
                        input logic [31:0] alu, input logic [31:0] pc4);
    logic [31:0] d;
    d = (sel == WB_SEL_PC4) ? pc4 : alu;
    @(negedge clk);
    start = 1'b1; wb_sel = sel; rd = r; alu_result = alu; pc_plus4 = pc4;
    push(cyc + 1, (r != 0) && (sel != WB_SEL_NONE), r, d, sel != WB_SEL_NONE, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Load: fault completes immediately; otherwise rvalid is raised `dly` cycles
  // after the request is accepted and the write follows one cycle later.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] word, input int dly);
    logic        flt;
    logic [31:0] d;
    model_load(addr[1:0], f3, word, flt, d);
    @(negedge clk);
    start = 1'b1; wb_sel = WB_SEL_MEM; rd = r; funct3 = f3; alu_result = addr;
    if (flt) push(cyc + 1, 1'b0, r, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    if (!flt) begin
      repeat (dly) @(negedge clk);
      mem_rdata = word; mem_rvalid = 1'b1;
      push(cyc + 1, r != 0, r, d, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wb_sel = WB_SEL_ALU; rd = '0; funct3 = '0;
    alu_result = '0; pc_plus4 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_w_addr", {27'h0, w_addr}, 32'h0);
    check("rst_w_data", w_data, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wb_next", {29'h0, wb_next}, {29'h0, CTRL_STATE_WB});
    rst = 1'b0;
    @(negedge clk);

    do_reg(WB_SEL_ALU, 5'd5, 32'hDEADBEEF, 32'h0);
    do_reg(WB_SEL_PC4, 5'd0, 32'h0, 32'h104);
    do_reg(WB_SEL_PC4, 5'd31, 32'h5, 32'h0000_2004);
    do_reg(WB_SEL_NONE, 5'd7, 32'h1234_5678, 32'h0);

    // busy during the completion cycle of a register writeback
    @(negedge clk);
    start = 1'b1; wb_sel = WB_SEL_ALU; rd = 5'd1; alu_result = 32'h55;
    push(cyc + 1, 1'b1, 5'd1, 32'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("busy_write", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("busy_after", {31'h0, busy}, 32'h0);

    // stray rvalid while idle must not complete anything
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);

    do_load(32'h0000_1003, F3_LB, 5'd10, 32'h80FF_1234, 3);
    do_load(32'h0000_2002, F3_LHU, 5'd11, 32'hBEEF_0000, 1);
    do_load(32'h0000_3001, F3_LW, 5'd12, 32'h0, 0);
    check("fault_no_wait", {31'h0, busy}, 32'h0);
    do_load(32'h0000_5000, F3_LW, 5'd0, 32'hCAFE_F00D, 0);

    for (int f = 0; f < 8; f++) begin
      for (int a = 0; a < 4; a++) begin
        do_load(32'h0000_4000 + a, 3'(f), 5'(1 + (f * 4 + a) % 31), $urandom, $urandom_range(0, 3));
      end
    end

    // start while waiting for memory is ignored
    @(negedge clk);
    start = 1'b1; wb_sel = WB_SEL_MEM; rd = 5'd9; funct3 = F3_LW; alu_result = 32'h100;
    @(negedge clk);
    wb_sel = WB_SEL_ALU; rd = 5'd3; alu_result = 32'h7777;
    repeat (2) @(negedge clk);
    start = 1'b0;
    mem_rdata = 32'h0BAD_F00D; mem_rvalid = 1'b1;
    push(cyc + 1, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);

    // reset during WAIT_MEM drops the pending load
    start = 1'b1; wb_sel = WB_SEL_MEM; rd = 5'd8; funct3 = F3_LW; alu_result = 32'h200;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_waiting", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    mem_rdata = 32'h1111_2222; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("late_rvalid_busy", {31'h0, busy}, 32'h0);

`ifdef WB_LOAD_TIMEOUT_EN
    // no response: timeout 4 cycles after WAIT_MEM is entered
    start = 1'b1; wb_sel = WB_SEL_MEM; rd = 5'd6; funct3 = F3_LW; alu_result = 32'h300;
    push(cyc + 5, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    // rvalid on the limit cycle wins over the timeout
    start = 1'b1; wb_sel = WB_SEL_MEM; rd = 5'd6; funct3 = F3_LW; alu_result = 32'h304;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    mem_rdata = 32'hA5A5_5A5A; mem_rvalid = 1'b1;
    push(cyc + 1, 1'b1, 5'd6, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final stage of the multi-cycle RV32I core; the write side of the register file that decode reads.
- Accepts a writeback request from the control FSM and selects the result source: ALU result, PC+4, or a memory load.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the data.
- Drives a one-cycle register-file write, then returns the control FSM to fetch.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_MEM before bus_timeout fires. Used only with WB_LOAD_TIMEOUT_EN.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request writeback this cycle; ignored unless state is IDLE
- wb_sel  input  2  result source: 00 ALU, 01 MEM, 10 PC4, 11 none
- rd  input  5  destination register
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- alu_result  input  32  ALU result; for loads this is the byte address
- pc_plus4  input  32  link value for JAL/JALR
- mem_rvalid  input  1  load data valid, single-cycle pulse
- mem_rdata  input  32  word-aligned load data
- wr_en  output  1  register-file write enable
- w_addr  output  5  register-file write address
- w_data  output  32  register-file write data
- done  output  1  one-cycle completion pulse
- busy  output  1  high when state is not IDLE
- load_fault  output  1  one-cycle pulse: misaligned or illegal load
- bus_timeout  output  1  one-cycle pulse; present only with WB_LOAD_TIMEOUT_EN
- wb_next  output  3  next control state

Behaviour:
- States: IDLE, WAIT_MEM, WRITE.
- All outputs are registered. On reset: state IDLE; wr_en, w_addr, w_data, done, busy, load_fault and bus_timeout are 0; wb_next is CTRL_STATE_WB.
- On start in IDLE, latch rd, wb_sel, funct3, alu_result[1:0], alu_result and pc_plus4.
- IDLE + start, wb_sel 00/10/11: go to WRITE.
  - WRITE lasts exactly 1 cycle: wr_en = (rd != 0) and (sel != 11); w_data = the selected source; done = 1; wb_next = CTRL_STATE_FETCH.
  - Then return to IDLE.
  - Latency: start at cycle N gives wr_en and done at cycle N+1.
- IDLE + start, wb_sel 01 (MEM): check the load first.
  - Fault: funct3 not in {000, 001, 010, 100, 101}, or LH/LHU with addr[0] = 1, or LW with addr[1:0] != 0.
  - On fault: next cycle pulses load_fault and done; wr_en = 0; wb_next = CTRL_STATE_FETCH; return to IDLE.
  - Otherwise go to WAIT_MEM.
- WAIT_MEM: wait for mem_rvalid.
  - mem_rvalid sampled at cycle M: align and extend mem_rdata, go to WRITE; wr_en and done at M+1.
  - The same-cycle case also holds: mem_rvalid at N+1 gives write at N+2.
- Load alignment:
  - Byte lane = mem_rdata[8*addr+7 : 8*addr].
  - Halfword = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Boundary rules:
  - mem_rvalid outside WAIT_MEM is ignored.
  - start while busy is ignored; no queuing.
  - rd = 0 completes normally (done pulses) but wr_en stays 0.
  - wb_next is CTRL_STATE_WB in every cycle except the done cycle.
  - Reset in any state returns to IDLE and drops any pending load; a late mem_rvalid after reset is ignored.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to WAIT_MEM and increments every cycle there.
  - When the count reaches TIMEOUT_CYCLES with no mem_rvalid, pulse bus_timeout and done, keep wr_en = 0, set wb_next = CTRL_STATE_FETCH, go to IDLE.
  - mem_rvalid in the same cycle as the limit wins: normal write, no timeout.
- Undefined: bus_timeout port and counter are absent; WAIT_MEM waits indefinitely.

Decomposition:
- Shared package holds:
  - wb_sel encodings: WB_SEL_ALU, WB_SEL_MEM, WB_SEL_PC4, WB_SEL_NONE.
  - Load funct3 constants.
  - The state enum.
  - CTRL_STATE_WB / CTRL_STATE_FETCH, from ctrl_states.
- One sub-module: load_align (combinational; addr[1:0], funct3, mem_rdata → 32-bit result and a fault flag), reused by the fault check and the data path.

Test Plan:
- ALU path: start, wb_sel 00, rd 5, alu_result 0xDEADBEEF → next cycle: wr_en 1, w_addr 5, w_data 0xDEADBEEF, done 1, wb_next FETCH.
- PC4 path with rd 0: start, wb_sel 10, rd 0, pc_plus4 0x104 → done 1, wr_en 0.
- LB sign-extend: addr 0x1003, mem_rdata 0x80FF_1234, mem_rvalid 3 cycles later → w_data 0xFFFFFF80, one cycle after rvalid.
- LHU: addr 0x2002, mem_rdata 0xBEEF_0000 → w_data 0x0000BEEF.
- Misaligned LW: addr 0x3001 → load_fault 1, done 1, wr_en 0, no WAIT_MEM entry.
- Reset mid-WAIT_MEM, then mem_rvalid → no write, busy 0. With the macro and TIMEOUT_CYCLES = 4 and no rvalid → bus_timeout pulses 4 cycles after entering WAIT_MEM.
